// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared constants for the RV32IM pipeline registers (ID/EX, EX/MEM, MEM/WB).
// Holds the default field widths, the all-zero NOP/bubble values that a
// cleared pipeline register must present, and the memory read/write codes.
package pipeline_pkg;

  // Default field widths
  localparam int XLEN    = 32;
  localparam int INSTR_W = 5;
  localparam int RW_W    = 4;
  localparam int WB_W    = 2;

  // Memory read/write control encodings; only "idle" is fixed here because
  // a bubble must never touch memory.
  localparam logic [RW_W-1:0] RW_IDLE = 4'd0;

  // NOP / reset values: an all-zero register is a bubble
  // (no register write, no memory access).
  localparam logic [INSTR_W-1:0] NOP_INSTRUCTION = 5'd0;
  localparam logic [XLEN-1:0]    NOP_XLEN        = 32'd0;
  localparam logic               NOP_BIT         = 1'b0;
  localparam logic [RW_W-1:0]    NOP_READ_WRITE  = RW_IDLE;
  localparam logic [WB_W-1:0]    NOP_WB_SEL      = 2'd0;

endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg
// Generic W-bit pipeline field register: synchronous clear to RESET_VAL,
// hold while stalled, otherwise load d on the rising edge.
// Ports:
//   clk   - clock, rising edge active
//   clear - synchronous clear, has priority over hold
//   hold  - 1 = keep the current value
//   d     - next value
//   q     - registered value
module pipe_field_reg #(
  parameter int             W         = 1,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field register: clear wins over hold, hold wins over load
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= RESET_VAL;
    end else if (hold) begin
      q <= q;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// ex_mem_pipeline_reg
// EX/MEM pipeline register of the 5-stage RV32IM core. Captures the EX-stage
// results and downstream control on every rising edge, freezes while the
// data memory signals BUSYWAIT, and clears to a bubble on synchronous RESET.
// Ports:
//   IN_*     - EX-stage values (rd field, PC, ALU result, rs2 data, immediate,
//              data-memory select, memory op code, write-back select,
//              register-file write enable)
//   OUT_*    - registered copies of the matching IN_* fields
//   CLK      - clock, rising edge active
//   RESET    - synchronous active-high clear (wins over BUSYWAIT)
//   BUSYWAIT - 1 = hold all fields
module ex_mem_pipeline_reg #(
  parameter int INSTR_W = pipeline_pkg::INSTR_W,
  parameter int XLEN    = pipeline_pkg::XLEN,
  parameter int RW_W    = pipeline_pkg::RW_W,
  parameter int WB_W    = pipeline_pkg::WB_W
) (
  input  logic [INSTR_W-1:0] IN_INSTRUCTION,
  input  logic [XLEN-1:0]    IN_PC,
  input  logic [XLEN-1:0]    IN_ALU_RESULT,
  input  logic [XLEN-1:0]    IN_DATA2,
  input  logic [XLEN-1:0]    IN_IMMEDIATE,
  input  logic               IN_DATAMEMSEL,
  input  logic [RW_W-1:0]    IN_READ_WRITE,
  input  logic [WB_W-1:0]    IN_WB_SEL,
  input  logic               IN_REG_WRITE_EN,
  output logic [INSTR_W-1:0] OUT_INSTRUCTION,
  output logic [XLEN-1:0]    OUT_PC,
  output logic [XLEN-1:0]    OUT_ALU_RESULT,
  output logic [XLEN-1:0]    OUT_DATA2,
  output logic [XLEN-1:0]    OUT_IMMEDIATE,
  output logic               OUT_DATAMEMSEL,
  output logic [RW_W-1:0]    OUT_READ_WRITE,
  output logic [WB_W-1:0]    OUT_WB_SEL,
  output logic               OUT_REG_WRITE_EN,
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BUSYWAIT
);

  import pipeline_pkg::*;

  // Every field shares the same clear/hold so the stage updates atomically.
  pipe_field_reg #(.W(INSTR_W), .RESET_VAL(INSTR_W'(NOP_INSTRUCTION))) u_instruction (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_INSTRUCTION), .q(OUT_INSTRUCTION)
  );

  pipe_field_reg #(.W(XLEN), .RESET_VAL(XLEN'(NOP_XLEN))) u_pc (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_PC), .q(OUT_PC)
  );

  pipe_field_reg #(.W(XLEN), .RESET_VAL(XLEN'(NOP_XLEN))) u_alu_result (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_ALU_RESULT), .q(OUT_ALU_RESULT)
  );

  pipe_field_reg #(.W(XLEN), .RESET_VAL(XLEN'(NOP_XLEN))) u_data2 (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_DATA2), .q(OUT_DATA2)
  );

  pipe_field_reg #(.W(XLEN), .RESET_VAL(XLEN'(NOP_XLEN))) u_immediate (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_IMMEDIATE), .q(OUT_IMMEDIATE)
  );

  pipe_field_reg #(.W(1), .RESET_VAL(NOP_BIT)) u_datamemsel (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_DATAMEMSEL), .q(OUT_DATAMEMSEL)
  );

  // A cleared op code is RW_IDLE so a bubble never accesses memory.
  pipe_field_reg #(.W(RW_W), .RESET_VAL(RW_W'(NOP_READ_WRITE))) u_read_write (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_READ_WRITE), .q(OUT_READ_WRITE)
  );

  pipe_field_reg #(.W(WB_W), .RESET_VAL(WB_W'(NOP_WB_SEL))) u_wb_sel (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_WB_SEL), .q(OUT_WB_SEL)
  );

  pipe_field_reg #(.W(1), .RESET_VAL(NOP_BIT)) u_reg_write_en (
    .clk(CLK), .clear(RESET), .hold(BUSYWAIT), .d(IN_REG_WRITE_EN), .q(OUT_REG_WRITE_EN)
  );

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// tb_ex_mem_pipeline_reg
// Self-checking bench for ex_mem_pipeline_reg: a table of directed vectors,
// hand-written multi-cycle sequences, and randomized cycles checked against
// a simple "stage contents" reference model.
module tb_ex_mem_pipeline_reg;

  typedef struct packed {
    logic [4:0]  instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data2;
    logic [31:0] imm;
    logic        dms;
    logic [3:0]  rw;
    logic [1:0]  wb;
    logic        we;
  } fields_t;

  typedef struct {
    string   name;
    logic    rst;
    logic    busy;
    fields_t in;
    fields_t exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        busywait;
  logic [4:0]  in_instruction;
  logic [31:0] in_pc, in_alu_result, in_data2, in_immediate;
  logic        in_datamemsel;
  logic [3:0]  in_read_write;
  logic [1:0]  in_wb_sel;
  logic        in_reg_write_en;
  logic [4:0]  out_instruction;
  logic [31:0] out_pc, out_alu_result, out_data2, out_immediate;
  logic        out_datamemsel;
  logic [3:0]  out_read_write;
  logic [1:0]  out_wb_sel;
  logic        out_reg_write_en;

  int n_vec = 0;
  int n_err = 0;

  ex_mem_pipeline_reg dut (
    .IN_INSTRUCTION  (in_instruction),
    .IN_PC           (in_pc),
    .IN_ALU_RESULT   (in_alu_result),
    .IN_DATA2        (in_data2),
    .IN_IMMEDIATE    (in_immediate),
    .IN_DATAMEMSEL   (in_datamemsel),
    .IN_READ_WRITE   (in_read_write),
    .IN_WB_SEL       (in_wb_sel),
    .IN_REG_WRITE_EN (in_reg_write_en),
    .OUT_INSTRUCTION (out_instruction),
    .OUT_PC          (out_pc),
    .OUT_ALU_RESULT  (out_alu_result),
    .OUT_DATA2       (out_data2),
    .OUT_IMMEDIATE   (out_immediate),
    .OUT_DATAMEMSEL  (out_datamemsel),
    .OUT_READ_WRITE  (out_read_write),
    .OUT_WB_SEL      (out_wb_sel),
    .OUT_REG_WRITE_EN(out_reg_write_en),
    .CLK             (clk),
    .RESET           (reset),
    .BUSYWAIT        (busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fields_t mk(input int i, input int p, input int a, input int d,
                                 input int m, input int s, input int r, input int w,
                                 input int e);
    fields_t f;
    f.instr = i[4:0];
    f.pc    = p;
    f.alu   = a;
    f.data2 = d;
    f.imm   = m;
    f.dms   = s[0];
    f.rw    = r[3:0];
    f.wb    = w[1:0];
    f.we    = e[0];
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.instr = 5'($urandom);
    f.pc    = $urandom;
    f.alu   = $urandom;
    f.data2 = $urandom;
    f.imm   = $urandom;
    f.dms   = 1'($urandom);
    f.rw    = 4'($urandom);
    f.wb    = 2'($urandom);
    f.we    = 1'($urandom);
    return f;
  endfunction

  task automatic drive(input fields_t f);
    in_instruction  = f.instr;
    in_pc           = f.pc;
    in_alu_result   = f.alu;
    in_data2        = f.data2;
    in_immediate    = f.imm;
    in_datamemsel   = f.dms;
    in_read_write   = f.rw;
    in_wb_sel       = f.wb;
    in_reg_write_en = f.we;
  endtask

  task automatic check(input string name, input fields_t exp);
    fields_t got;
    got = {out_instruction, out_pc, out_alu_result, out_data2, out_immediate,
           out_datamemsel, out_read_write, out_wb_sel, out_reg_write_en};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Apply one cycle: set controls and inputs, take an edge, sample 3 units later.
  task automatic step(input logic r, input logic b, input fields_t f);
    reset    = r;
    busywait = b;
    drive(f);
    @(posedge clk);
    #3;
  endtask

  vec_t    vecs[9];
  fields_t zero;
  fields_t ones;
  fields_t model;
  fields_t va;
  fields_t vb;

  initial begin
    zero = '0;
    ones = '1;

    vecs[0] = '{"reset",          1'b1, 1'b0, mk(15, 23, 45, 33, 56, 1, 1, 3, 1), zero};
    vecs[1] = '{"capture",        1'b0, 1'b0, mk(10, 20, 30, 40, 50, 1, 1, 1, 1),
                mk(10, 20, 30, 40, 50, 1, 1, 1, 1)};
    vecs[2] = '{"stall",          1'b0, 1'b1, mk(30, 70, 80, 50, 90, 0, 3, 3, 0),
                mk(10, 20, 30, 40, 50, 1, 1, 1, 1)};
    vecs[3] = '{"stall_release",  1'b0, 1'b0, mk(30, 70, 80, 50, 90, 0, 3, 3, 0),
                mk(30, 70, 80, 50, 90, 0, 3, 3, 0)};
    vecs[4] = '{"reset_in_stall", 1'b1, 1'b1, mk(1, 2, 3, 4, 5, 1, 2, 1, 1), zero};
    vecs[5] = '{"all_ones",       1'b0, 1'b0, ones, ones};
    vecs[6] = '{"ones_held",      1'b0, 1'b1, zero, ones};
    vecs[7] = '{"ones_held2",     1'b0, 1'b1, mk(7, 7, 7, 7, 7, 0, 7, 2, 0), ones};
    vecs[8] = '{"reset_ones",     1'b1, 1'b1, ones, zero};

    reset    = 1'b0;
    busywait = 1'b0;
    drive(zero);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].busy, vecs[i].in);
      check(vecs[i].name, vecs[i].exp);
    end

    // Inputs toggled between edges must not reach the outputs
    va = mk(3, 100, 200, 300, 400, 1, 5, 2, 1);
    vb = mk(9, 900, 800, 700, 600, 0, 9, 1, 0);
    step(1'b0, 1'b0, va);
    check("mid_capture", va);
    drive(vb);
    #2;
    check("mid_toggle1", va);
    drive(rand_fields());
    #2;
    drive(vb);
    #1;
    check("mid_toggle2", va);
    @(posedge clk);
    #3;
    check("mid_next_edge", vb);

    // Reset raised between edges acts only on the next edge
    #1;
    reset = 1'b1;
    #2;
    check("async_reset_ignored", vb);
    @(posedge clk);
    #3;
    check("reset_at_edge", zero);
    reset = 1'b0;

    // Long stall with inputs changing every cycle
    step(1'b0, 1'b0, va);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, rand_fields());
      check("long_stall", va);
    end

    // Randomized cycles against the stage-contents model
    model = zero;
    step(1'b1, 1'b0, rand_fields());
    check("rand_reset", model);
    for (int i = 0; i < 400; i++) begin
      fields_t f;
      logic r;
      logic b;
      f = rand_fields();
      r = ($urandom_range(15) == 0);
      b = ($urandom_range(2) == 0);
      if (r) model = zero;
      else if (!b) model = f;
      step(r, b, f);
      check("random", model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
